// File: rtl/perceptron_net_sequencer.sv
// Two-layer, three-neuron step-activation network evaluated on one shared accumulator.
// Default weights give y = a XOR b.
module perceptron_net_sequencer #(
   parameter int unsigned W_WIDTH   = 8,
   parameter int unsigned ACC_WIDTH = 12
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic               a,
   input  logic               b,
   input  logic               cfg_we,
   input  logic [3:0]         cfg_addr,
   input  logic [W_WIDTH-1:0] cfg_data,
   output logic               busy,
   output logic               done,
   output logic               y,
   output logic               h0,
   output logic               h1
);

   localparam logic [0:0] StIdle = 1'b0;
   localparam logic [0:0] StRun  = 1'b1;

   logic [0:0]           state_q, state_d;
   logic [1:0]           n_q, n_d;
   logic [1:0]           s_q, s_d;
   logic [1:0]           x_q, x_d;
   logic [ACC_WIDTH-1:0] acc_q, acc_d;
   logic                 h0_q, h0_d, h1_q, h1_d, y_q, y_d, done_q, done_d;
   logic [W_WIDTH-1:0]   tbl_q [9];
   logic [W_WIDTH-1:0]   tbl_d [9];

   logic [3:0]           base;
   logic                 in0, in1, act;
   logic [ACC_WIDTH-1:0] result;

   // Table layout: 3*neuron + {bias, w0, w1}; defaults form NAND, OR, AND.
   function automatic logic [W_WIDTH-1:0] default_weight(input int idx);
      case (idx)
         0:       return W_WIDTH'(10);
         1, 2:    return W_WIDTH'(-10);
         3:       return W_WIDTH'(-10);
         6:       return W_WIDTH'(-30);
         default: return W_WIDTH'(20);
      endcase
   endfunction

   function automatic logic [ACC_WIDTH-1:0] sext(input logic [W_WIDTH-1:0] w);
      return {{(ACC_WIDTH - W_WIDTH){w[W_WIDTH-1]}}, w};
   endfunction

   always_comb begin
      case (n_q)
         2'd0:    base = 4'd0;
         2'd1:    base = 4'd3;
         default: base = 4'd6;
      endcase
   end

   // The output neuron takes the hidden results of the current run as inputs.
   assign in0    = (n_q == 2'd2) ? h0_q : x_q[0];
   assign in1    = (n_q == 2'd2) ? h1_q : x_q[1];
   assign result = acc_q + (in1 ? sext(tbl_q[base + 4'd2]) : '0);
   assign act    = ~result[ACC_WIDTH-1];

   always_comb begin
      state_d = state_q;
      n_d     = n_q;
      s_d     = s_q;
      x_d     = x_q;
      acc_d   = acc_q;
      h0_d    = h0_q;
      h1_d    = h1_q;
      y_d     = y_q;
      done_d  = 1'b0;
      tbl_d   = tbl_q;

      if (state_q == StIdle && cfg_we && cfg_addr < 4'd9) begin
         tbl_d[cfg_addr] = cfg_data;
      end

      case (state_q)
         StIdle: begin
            if (start) begin
               state_d = StRun;
               x_d     = {b, a};
               n_d     = 2'd0;
               s_d     = 2'd0;
            end
         end
         default: begin
            case (s_q)
               2'd0: begin
                  acc_d = sext(tbl_q[base]);
                  s_d   = 2'd1;
               end
               2'd1: begin
                  acc_d = acc_q + (in0 ? sext(tbl_q[base + 4'd1]) : '0);
                  s_d   = 2'd2;
               end
               default: begin
                  s_d = 2'd0;
                  case (n_q)
                     2'd0:    h0_d = act;
                     2'd1:    h1_d = act;
                     default: y_d  = act;
                  endcase
                  if (n_q == 2'd2) begin
                     state_d = StIdle;
                     done_d  = 1'b1;
                  end else begin
                     n_d = n_q + 2'd1;
                  end
               end
            endcase
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= StIdle;
         n_q     <= 2'd0;
         s_q     <= 2'd0;
         x_q     <= 2'b00;
         acc_q   <= '0;
         h0_q    <= 1'b0;
         h1_q    <= 1'b0;
         y_q     <= 1'b0;
         done_q  <= 1'b0;
         for (int i = 0; i < 9; i++) begin
            tbl_q[i] <= default_weight(i);
         end
      end else begin
         state_q <= state_d;
         n_q     <= n_d;
         s_q     <= s_d;
         x_q     <= x_d;
         acc_q   <= acc_d;
         h0_q    <= h0_d;
         h1_q    <= h1_d;
         y_q     <= y_d;
         done_q  <= done_d;
         tbl_q   <= tbl_d;
      end
   end

   assign busy = (state_q == StRun);
   assign done = done_q;
   assign y    = y_q;
   assign h0   = h0_q;
   assign h1   = h1_q;

endmodule
